// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shifter: instruction fields, shift modes and FSM states.
package shifter_pkg;

    localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_ROTR = 6'b000001;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;

    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA, SH_ROR} shmode_e;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves the word by k positions in the selected mode.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = 3
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [KW-1:0]    k_i,
    input  shmode_e          mode_i,
    output logic [WIDTH-1:0] data_o
);

    logic [2*WIDTH-1:0] dbl_s;

    // Rotate is taken from the low half of the doubled word shifted right.
    always_comb begin
        dbl_s = {data_i, data_i} >> k_i;
        case (mode_i)
            SH_LL:   data_o = data_i << k_i;
            SH_RL:   data_o = data_i >> k_i;
            SH_RA:   data_o = $signed(data_i) >>> k_i;
            SH_ROR:  data_o = dbl_s[WIDTH-1:0];
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_iter_unit.sv
// Multi-cycle MIPS shifter (sll/srl/sra, variable forms, rotr) with start/busy/done handshake.
module shift_iter_unit
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic [WIDTH-1:0] rs_val_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             illegal_o
);

    localparam int KW = $clog2(STEP + 1);
    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] STEP_C = CW'(STEP);
    localparam logic [KW-1:0] STEP_K = KW'(STEP);

    state_e           state_q, state_d;
    shmode_e          mode_q, mode_d, dec_mode_s;
    logic [WIDTH-1:0] work_q, work_d, step_s;
    logic [SHW-1:0]   cnt_q, cnt_d, amt_s;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;
    logic             legal_s, var_amt_s, last_s;
    logic [KW-1:0]    k_s;

    // Instruction decode: mode, legality and which operand supplies the amount.
    always_comb begin
        dec_mode_s = SH_LL;
        legal_s    = 1'b0;
        var_amt_s  = 1'b0;
        if (opcode_i == OPCODE_RTYPE) begin
            case (funct_i)
                FUNCT_SLL:  begin legal_s = 1'b1; dec_mode_s = SH_LL;  end
                FUNCT_ROTR: begin legal_s = 1'b1; dec_mode_s = SH_ROR; end
                FUNCT_SRL:  begin legal_s = 1'b1; dec_mode_s = SH_RL;  end
                FUNCT_SRA:  begin legal_s = 1'b1; dec_mode_s = SH_RA;  end
                FUNCT_SLLV: begin legal_s = 1'b1; dec_mode_s = SH_LL; var_amt_s = 1'b1; end
                FUNCT_SRLV: begin legal_s = 1'b1; dec_mode_s = SH_RL; var_amt_s = 1'b1; end
                FUNCT_SRAV: begin legal_s = 1'b1; dec_mode_s = SH_RA; var_amt_s = 1'b1; end
                default:    begin legal_s = 1'b0; end
            endcase
        end else begin
            legal_s = 1'b0;
        end
    end

    assign amt_s = var_amt_s ? rs_val_i[SHW-1:0] : shamt_i;

    // Per-cycle step size k = min(STEP, cnt); the step that empties cnt is the last one.
    always_comb begin
        if ({1'b0, cnt_q} < STEP_C) begin
            k_s = KW'(cnt_q);
        end else begin
            k_s = STEP_K;
        end
        last_s = ({1'b0, cnt_q} <= STEP_C);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .data_i (work_q),
        .k_i    (k_s),
        .mode_i (mode_q),
        .data_o (step_s)
    );

    // Next-state and registered-output logic; outputs are computed one cycle ahead.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && legal_s) begin
                    state_d = S_SHIFT;
                    work_d  = value_i;
                    cnt_d   = amt_s;
                    mode_d  = dec_mode_s;
                    busy_d  = 1'b1;
                end else if (start_i) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    result_d  = {WIDTH{1'b0}};
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                work_d = step_s;
                cnt_d  = cnt_q - SHW'(k_s);
                busy_d = 1'b1;
                if (last_s) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    result_d  = step_s;
                    illegal_d = 1'b0;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            work_q    <= {WIDTH{1'b0}};
            cnt_q     <= {SHW{1'b0}};
            mode_q    <= SH_LL;
            result_q  <= {WIDTH{1'b0}};
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign result_o  = result_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_shift_iter_unit.sv
// Directed self-checking bench for shift_iter_unit (WIDTH=32, STEP=4).
module tb_shift_iter_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [5:0]  opcode_i;
    logic [5:0]  funct_i;
    logic [31:0] value_i;
    logic [4:0]  shamt_i;
    logic [31:0] rs_val_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        illegal_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_iter_unit #(
        .WIDTH (32),
        .STEP  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .opcode_i  (opcode_i),
        .funct_i   (funct_i),
        .value_i   (value_i),
        .shamt_i   (shamt_i),
        .rs_val_i  (rs_val_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .illegal_o (illegal_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Launch one op, track busy every cycle, measure cycles from acceptance edge to done.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic [31:0] val, input logic [4:0] sh, input logic [31:0] rs,
                          input logic [31:0] exp_res, input logic exp_ill, input int exp_lat,
                          input bit poke);
        int lat;
        bit seen;
        @(negedge clk);
        opcode_i = op; funct_i = fn; value_i = val; shamt_i = sh; rs_val_i = rs; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0; value_i = ~val; shamt_i = ~sh; rs_val_i = ~rs;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 2) begin
                opcode_i = 6'b000000; funct_i = 6'b000010; value_i = 32'hFFFF_FFFF;
                shamt_i = 5'd1; start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            chk({tag, " busy"}, {31'd0, busy_o}, {31'd0, ~exp_ill});
            if (done_o) seen = 1'b1;
        end
        chk({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " result"}, result_o, exp_res);
        chk({tag, " illegal"}, {31'd0, illegal_o}, {31'd0, exp_ill});
        if (poke) begin
            opcode_i = 6'b000000; funct_i = 6'b000000; value_i = 32'hFFFF_FFFF;
            shamt_i = 5'd1; start_i = 1'b1;
        end else begin
            start_i = 1'b0;
        end
        @(negedge clk);
        start_i = 1'b0;
        chk({tag, " done_pulse_end"}, {31'd0, done_o}, 32'd0);
        chk({tag, " idle_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, " result_hold"}, result_o, exp_res);
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; opcode_i = 6'd0; funct_i = 6'd0;
        value_i = 32'd0; shamt_i = 5'd0; rs_val_i = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy_o}, 32'd0);
        chk("reset done", {31'd0, done_o}, 32'd0);
        chk("reset result", result_o, 32'd0);
        chk("reset illegal", {31'd0, illegal_o}, 32'd0);
        rst_n = 1'b1;

        run_op("sll31", 6'd0, 6'b000000, 32'h0000_0001, 5'd31, 32'd0, 32'h8000_0000, 1'b0, 9, 1'b0);
        run_op("sra4",  6'd0, 6'b000011, 32'h8000_0000, 5'd4,  32'd0, 32'hF800_0000, 1'b0, 2, 1'b0);
        run_op("srl4",  6'd0, 6'b000010, 32'h8000_0000, 5'd4,  32'd0, 32'h0800_0000, 1'b0, 2, 1'b0);
        run_op("srav5", 6'd0, 6'b000111, 32'hFFFF_0000, 5'd0,  32'hFFFF_FFE5, 32'hFFFF_F800, 1'b0, 3, 1'b0);
        run_op("rotr8", 6'd0, 6'b000001, 32'h1234_5678, 5'd8,  32'd0, 32'h7812_3456, 1'b0, 3, 1'b0);
        run_op("rotr0", 6'd0, 6'b000001, 32'h1234_5678, 5'd0,  32'd0, 32'h1234_5678, 1'b0, 2, 1'b0);
        run_op("sllv3", 6'd0, 6'b000100, 32'h0000_000F, 5'd17, 32'h0000_0023, 32'h0000_0078, 1'b0, 2, 1'b0);
        run_op("srlv4", 6'd0, 6'b000110, 32'hF000_0000, 5'd9,  32'h0000_0104, 32'h0F00_0000, 1'b0, 2, 1'b0);
        run_op("ill_funct", 6'd0, 6'b100000, 32'hDEAD_BEEF, 5'd3, 32'd0, 32'd0, 1'b1, 1, 1'b0);
        run_op("ill_opcode", 6'b001000, 6'b000000, 32'hDEAD_BEEF, 5'd3, 32'd0, 32'd0, 1'b1, 1, 1'b0);
        run_op("sra31", 6'd0, 6'b000011, 32'h8000_0000, 5'd31, 32'd0, 32'hFFFF_FFFF, 1'b0, 9, 1'b0);
        run_op("second_start", 6'd0, 6'b000000, 32'h0000_0001, 5'd31, 32'd0, 32'h8000_0000, 1'b0, 9, 1'b1);

        @(negedge clk);
        opcode_i = 6'd0; funct_i = 6'b000000; value_i = 32'h0000_0001; shamt_i = 5'd31; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("midshift busy", {31'd0, busy_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset busy", {31'd0, busy_o}, 32'd0);
        chk("midreset done", {31'd0, done_o}, 32'd0);
        chk("midreset result", result_o, 32'd0);
        chk("midreset illegal", {31'd0, illegal_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_reset_rotr4", 6'd0, 6'b000001, 32'h1234_5678, 5'd4, 32'd0, 32'h8123_4567, 1'b0, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_iter_unit.md
# shift_iter_unit

Parametrised, multi-cycle successor to the single-cycle combinational shifter in the execute stage. It handles the MIPS R-type shifts (sll/srl/sra), their variable-amount forms (sllv/srlv/srav) and a rotate-right.
- Operand width and shift distance per cycle are set by parameters, so the same block trades area for latency.
- The pipeline controller launches an operation with a start/busy/done handshake, stalls while `busy` is high and captures `result` on `done`.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥2.
- `STEP`, 4: maximum bit positions shifted per cycle; 1 ≤ STEP ≤ WIDTH.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; not overridden).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  launch request; accepted only when `busy`=0.
- `opcode`  in  6  instruction opcode; only 6'b000000 (R-type) is legal.
- `funct`  in  6  operation select.
- `value`  in  WIDTH  operand to shift (rt).
- `shamt`  in  SHW  immediate amount for sll/srl/sra/rotr.
- `rs_val`  in  WIDTH  register operand; bits [SHW-1:0] are the amount for the variable forms.
- `busy`  out  1  high from the cycle after acceptance until `done` is deasserted.
- `done`  out  1  one-cycle pulse when `result` is valid.
- `result`  out  WIDTH  shifted value; held until the next accepted start.
- `illegal`  out  1  qualifies `done`; unsupported opcode/funct.

## Operation
- funct decode:
  - 000000 sll.
  - 000001 rotr (team-defined).
  - 000010 srl.
  - 000011 sra.
  - 000100 sllv.
  - 000110 srlv.
  - 000111 srav.
  - Any other funct, or opcode≠0, is illegal.
- Amount selection: immediate forms use `shamt`; variable forms use `rs_val[SHW-1:0]`; upper `rs_val` bits are ignored.
- States:
  - IDLE: waits for `start`; no other activity.
  - SHIFT: working register, remaining count `cnt` and mode are live.
  - DONE: `done`=1 for exactly one cycle.
- IDLE→SHIFT on a legal start. The cycle of `start` latches `value` into the working register, the amount into `cnt` and the mode.
- IDLE→DONE directly on an illegal start: `result`=0, `illegal`=1.
- In SHIFT, each cycle:
  - shift by k = min(STEP, cnt) and set cnt ← cnt−k;
  - when cnt reaches 0 (or is already 0), go to DONE.
- DONE→IDLE unconditionally.
- Fill rules:
  - sll/sllv fill with 0 from the LSB.
  - srl/srlv fill with 0 from the MSB.
  - sra/srav replicate the original sign bit for every step.
  - rotr feeds the LSBs into the MSB.
- A `start` while `busy`=1 is ignored: no queueing, no error. A `start` in the DONE cycle is also ignored.
- `illegal` updates only when an operation completes and holds with `result`.

## Timing
- Reset (async assert, synchronous-release clocking assumed upstream) forces all of the following, including mid-operation, and the in-flight operation is discarded:
  - state=IDLE;
  - `busy`=0, `done`=0, `illegal`=0;
  - `result`=0;
  - `cnt`=0.
- Legal op accepted at edge N: SHIFT occupies max(1, ⌈amt/STEP⌉) cycles.
- `done` is high in cycle N+1+max(1, ⌈amt/STEP⌉), and `result` is valid in that same cycle.
- Illegal op accepted at edge N: `done`, `illegal` and `result`=0 appear in cycle N+1; `busy` stays 0.
- `busy` is registered; it is high in every SHIFT and DONE cycle.
- Next accepted start: at the earliest, the cycle after DONE.
- amt=0: one SHIFT cycle with no change; `result`=`value`.
- amt=WIDTH−1 is the worst case: ⌈(WIDTH−1)/STEP⌉+1 cycles to `done`.
- No combinational path from inputs to outputs.

## Structure
- Package `shifter_pkg` holds:
  - funct localparams (FUNCT_SLL … FUNCT_ROTR);
  - OPCODE_RTYPE;
  - the mode enum {SH_LL, SH_RL, SH_RA, SH_ROR};
  - the state enum {S_IDLE, S_SHIFT, S_DONE}.
- Sub-module `shift_step` is a combinational single-step shifter: inputs are the word, k (0..STEP) and mode; the output is the shifted word. It is instantiated once.
- The top level holds the FSM, counter and registers.

## Test plan
- WIDTH=32, STEP=4 for all scenarios.
- sll, value=0x00000001, shamt=31, start at N → `result`=0x80000000, `done` at N+9, `busy` high in N+1..N+9.
- sra, value=0x80000000, shamt=4 → `result`=0xF8000000, `done` at N+2; srl with the same inputs → 0x08000000.
- srav, value=0xFFFF0000, rs_val=0xFFFFFFE5 (amt=5) → `result`=0xFFFFF800, `done` at N+3.
- rotr, value=0x12345678, shamt=8 → `result`=0x78123456; shamt=0 → `result`=0x12345678, `done` at N+2.
- funct=6'b100000, and separately opcode=6'b001000 → `done`=1 and `illegal`=1 at N+1, `result`=0, `busy` never high.
- Control:
  - a second `start` during SHIFT is ignored and the first result is unaffected;
  - `rst_n` pulsed low mid-SHIFT → all outputs 0 immediately, and a fresh op after release completes correctly.
